dribbler_ctrl: RTL and testbench
================================

# dribbler_ctrl

Sequencing controller for the dribbler BLDC commutation block. It synchronises and debounces the raw hall inputs, and inserts dead-time blanking on every commutation step. It ramps the commanded PWM duty, gates the commutation enable with PWM, and latches a fault on stall or invalid hall code. It sits between the command interface and the commutation block's `h`/`en` inputs.

## Interface
- `PWM_BITS`, 8: duty and PWM counter width
- `DEAD_CYC`, 16: blanking length in clk cycles per commutation step (≥1)
- `RAMP_DIV`, 256: clk cycles per 1-LSB duty ramp step (≥1)
- `STALL_CYC`, 1000000: cycles without an accepted hall edge that trigger a stall fault
- `clk`, in, 1: system clock, rising edge
- `rst_n`, in, 1: reset, asynchronous, active-low
- `hall_raw`, in, 3: unsynchronised hall sensors
- `cmd_valid`, in, 1: new target duty offered
- `cmd_duty`, in, PWM_BITS: target duty
- `cmd_ready`, out, 1: command accepted when `cmd_valid & cmd_ready` at a rising edge
- `fault_clr`, in, 1: clears FAULT
- `hall_sync`, out, 3: hall code driven to the commutation block `h`
- `drv_en`, out, 1: commutation enable (already PWM-gated and blanked)
- `fault`, out, 1: fault latched
- `state`, out, 2: IDLE=00, RAMP=01, RUN=10, FAULT=11
- `period`, out, 24: cycles between accepted hall edges (see Configuration)

## Operation
- **Hall input path:**
  - Two-flop synchroniser, then a 3-cycle stability filter.
  - The synchronised value must be identical on 3 consecutive edges to become `hall_q`.
- **Accepted edge:** `hall_q` changes to a new value.
  - Starts blanking: `drv_en`=0 for exactly DEAD_CYC cycles.
  - `hall_sync` loads `hall_q` on the last blanking cycle, so the new pattern appears with enable already low.
  - A further accepted edge during blanking restarts the count and uses the latest code.
- **Invalid code:** `hall_q` of 000 or 111 while in RAMP/RUN forces FAULT. In IDLE it is ignored.
- **PWM:**
  - Free-running PWM_BITS counter, wraps 2^PWM_BITS−1 → 0.
  - `pwm = cnt < duty_cur`.
  - Duty 0 gives constant low; max duty gives (2^N−1)/2^N high.
- **Enable gating:** `drv_en = (state==RAMP|RUN) & ~blank & pwm`.
- **Command handshake:**
  - `cmd_ready` = (state != FAULT).
  - An accepted command loads `duty_tgt`.
- **Ramp:**
  - A ramp tick fires every RAMP_DIV cycles.
  - On each tick `duty_cur` moves 1 LSB toward `duty_tgt`. No overshoot, no wrap.
- **State machine:**
  - IDLE → RAMP when `duty_tgt` != 0.
  - RAMP → RUN when `duty_cur == duty_tgt` and != 0.
  - RUN → RAMP when `duty_tgt` != `duty_cur`.
  - RAMP → IDLE when both reach 0.
  - Any of RAMP/RUN → FAULT on stall or invalid code.
  - FAULT → IDLE on `fault_clr`.
- **Stall detection:**
  - A counter runs while `duty_cur` != 0 and resets on each accepted edge.
  - Reaching STALL_CYC sets FAULT.
- **Fault handling:**
  - Entering FAULT: `duty_cur`, `duty_tgt` and the stall counter are cleared, `fault`=1, `drv_en`=0.
  - `cmd_valid` in FAULT is not accepted.
  - `fault_clr` asserted together with a new fault condition: FAULT wins.

## Timing
- **Reset values:**
  - `hall_sync`=000, `drv_en`=0, `fault`=0, `state`=00, `period`=0, `cmd_ready`=1.
  - Internal duty, counters and filter all cleared.
- **Hall latency:**
  - A raw change stable from edge N is in `hall_q` at edge N+4.
  - `hall_sync` updates at edge N+4+DEAD_CYC.
  - `drv_en` may re-assert on the following cycle.
- **Command latency:** a command accepted at edge N is in `duty_tgt` at N. The state leaves IDLE at N+1.
- **Ramp timing:** from 0 to target D takes D·RAMP_DIV cycles (±RAMP_DIV for tick phase).
- **Mid-operation reset:** `rst_n` low mid-operation forces all outputs low/reset immediately, independent of clk.

## Configuration
- **`DRIBBLER_SPEED_EN` defined:**
  - A 24-bit counter measures cycles between accepted hall edges, saturating at 2^24−1.
  - `period` is loaded on each accepted edge and cleared on FAULT.
- **`DRIBBLER_SPEED_EN` undefined:** the counter is absent and `period` is constant 0.

## Test plan
- Reset with `hall_raw`=001 → all outputs at reset values. `hall_sync`=001 only after 4+DEAD_CYC cycles; `state` remains IDLE.
- Command `cmd_duty`=4, RAMP_DIV=4 → RAMP, `duty_cur` 1..4 at 4-cycle spacing, then RUN. `drv_en` high 4 of every 256 cycles.
- In RUN, step hall 001→011 → `drv_en` low exactly DEAD_CYC cycles. `hall_sync`=011 on the last blanked cycle.
- Hall glitch of 2 cycles → `hall_q` unchanged, no blanking. Hall 111 in RUN → FAULT and `cmd_ready`=0. `fault_clr` → IDLE.
- Duty 10 with frozen hall, STALL_CYC=100 → FAULT on cycle 100 after the last edge. Same-cycle `fault_clr` is ignored.
- With `DRIBBLER_SPEED_EN`, edges 500 cycles apart → `period`=500. Without it → `period`=0 throughout.

Source files
------------

// File: rtl/dribbler_ctrl.sv
// dribbler_ctrl: hall sync/debounce, dead-time blanking, duty ramp and fault FSM for the dribbler BLDC.
// Define DRIBBLER_SPEED_EN to add the hall edge period counter; otherwise period is tied to 0.
module dribbler_ctrl #(
  parameter int PWM_BITS  = 8,
  parameter int DEAD_CYC  = 16,
  parameter int RAMP_DIV  = 256,
  parameter int STALL_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          hall_raw,
  input  logic                cmd_valid,
  input  logic [PWM_BITS-1:0] cmd_duty,
  output logic                cmd_ready,
  input  logic                fault_clr,
  output logic [2:0]          hall_sync,
  output logic                drv_en,
  output logic                fault,
  output logic [1:0]          state,
  output logic [23:0]         period
);
  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam int SW = $clog2(STALL_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, RAMP = 2'b01, RUN = 2'b10, FLT = 2'b11} state_t;
  state_t st, st_nx;

  logic [2:0]          s1, s2, h1, h2, hall_q, hall_qd;
  logic [DW-1:0]       blank_cnt, blank_nx;
  logic [RW-1:0]       div_cnt;
  logic [SW-1:0]       stall_cnt;
  logic [PWM_BITS-1:0] cnt, duty_cur, duty_tgt;
  logic                edge_acc, blank, inv, stall, tick, active, go_flt;

  assign edge_acc  = hall_q != hall_qd;
  assign blank_nx  = edge_acc ? DW'(DEAD_CYC) : (blank_cnt != '0 ? blank_cnt - 1'b1 : '0);
  assign blank     = blank_cnt != '0;
  assign inv       = hall_q == 3'b000 || hall_q == 3'b111;
  assign stall     = stall_cnt == SW'(STALL_CYC);
  assign tick      = div_cnt == RW'(RAMP_DIV - 1);
  assign active    = st == RAMP || st == RUN;
  assign go_flt    = st_nx == FLT;
  assign drv_en    = active & ~blank & (cnt < duty_cur);
  assign cmd_ready = st != FLT;
  assign fault     = st == FLT;
  assign state     = st;

  // hall_sync takes the latest filtered code on the final blanked cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s1, s2, h1, h2, hall_q, hall_qd, hall_sync} <= '0;
      blank_cnt <= '0;
    end else begin
      s1 <= hall_raw;
      s2 <= s1;
      h1 <= s2;
      h2 <= h1;
      if (s2 == h1 && h1 == h2) hall_q <= s2;
      hall_qd   <= hall_q;
      blank_cnt <= blank_nx;
      if (blank_nx == DW'(1)) hall_sync <= hall_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: st_nx = duty_tgt != '0 ? RAMP : IDLE;
      RAMP: st_nx = (stall || inv) ? FLT :
                    duty_cur == duty_tgt ? (duty_cur != '0 ? RUN : IDLE) : RAMP;
      RUN:  st_nx = (stall || inv) ? FLT : duty_tgt != duty_cur ? RAMP : RUN;
      FLT:  st_nx = fault_clr ? IDLE : FLT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      div_cnt   <= '0;
      duty_cur  <= '0;
      duty_tgt  <= '0;
      stall_cnt <= '0;
    end else begin
      cnt     <= cnt + 1'b1;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (go_flt) begin
        duty_cur  <= '0;
        duty_tgt  <= '0;
        stall_cnt <= '0;
      end else begin
        if (cmd_valid && cmd_ready) duty_tgt <= cmd_duty;
        if (tick && duty_cur < duty_tgt) duty_cur <= duty_cur + 1'b1;
        else if (tick && duty_cur > duty_tgt) duty_cur <= duty_cur - 1'b1;
        stall_cnt <= (edge_acc || duty_cur == '0) ? '0 : stall ? stall_cnt : stall_cnt + 1'b1;
      end
    end
  end

`ifdef DRIBBLER_SPEED_EN
  logic [23:0] per_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      period  <= '0;
    end else if (go_flt) begin
      per_cnt <= '0;
      period  <= '0;
    end else if (edge_acc) begin
      period  <= per_cnt;
      per_cnt <= 24'd1;
    end else if (per_cnt != '1) begin
      per_cnt <= per_cnt + 1'b1;
    end
  end
`else
  assign period = '0;
`endif
endmodule

// File: tb/tb_dribbler_ctrl.sv
// tb_dribbler_ctrl: directed checks of hall filtering, blanking, ramp, PWM gating, faults and period.
module tb_dribbler_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  hall_raw;
  logic        cmd_valid;
  logic [7:0]  cmd_duty;
  logic        cmd_ready;
  logic        fault_clr;
  logic [2:0]  hall_sync;
  logic        drv_en;
  logic        fault;
  logic [1:0]  state;
  logic [23:0] period;
  logic [7:0]  cyc;
  int          errors = 0;
  int          total = 0;
  int          hi;

  dribbler_ctrl #(.PWM_BITS(8), .DEAD_CYC(5), .RAMP_DIV(4), .STALL_CYC(2000)) dut (
    .clk(clk), .rst_n(rst_n), .hall_raw(hall_raw), .cmd_valid(cmd_valid), .cmd_duty(cmd_duty),
    .cmd_ready(cmd_ready), .fault_clr(fault_clr), .hall_sync(hall_sync), .drv_en(drv_en),
    .fault(fault), .state(state), .period(period)
  );

  always #5 clk = ~clk;

  // free-running reference for the PWM counter phase
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 8'd0;
    else cyc <= cyc + 8'd1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; hall_raw = 3'b001; cmd_valid = 1'b0; cmd_duty = 8'd0; fault_clr = 1'b0;
    #22;
    check("rst_hall_sync", hall_sync, 3'b000);
    check("rst_drv_en", drv_en, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_state", state, 2'b00);
    check("rst_period", period, 24'd0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;
    step(9);
    check("hall_sync_before", hall_sync, 3'b000);
    step(1);
    check("hall_sync_after", hall_sync, 3'b001);
    check("idle_after_hall", state, 2'b00);

    cmd_valid = 1'b1; cmd_duty = 8'd4;
    step(1);
    cmd_valid = 1'b0;
    check("cmd_edge_idle", state, 2'b00);
    step(1);
    check("cmd_next_ramp", state, 2'b01);
    step(12);
    check("ramp_in_progress", state, 2'b01);
    step(7);
    check("ramp_to_run", state, 2'b10);
    hi = 0;
    repeat (256) begin
      step(1);
      hi += int'(drv_en);
    end
    check("pwm_high_4_of_256", hi, 4);

    cmd_valid = 1'b1; cmd_duty = 8'd255;
    step(1);
    cmd_valid = 1'b0;
    step(1);
    check("run_to_ramp", state, 2'b01);
    step(1020);
    check("ramp255_run", state, 2'b10);

    hall_raw = 3'b011;
    for (int k = 0; k < 14; k++) begin
      step(1);
      check($sformatf("blank_drv_en_%0d", k), drv_en, (k >= 5 && k <= 9) ? 1'b0 : (cyc != 8'hff));
      check($sformatf("blank_hall_sync_%0d", k), hall_sync, k >= 9 ? 3'b011 : 3'b001);
    end

    hall_raw = 3'b010;
    step(2);
    hall_raw = 3'b011;
    for (int k = 0; k < 12; k++) begin
      step(1);
      check($sformatf("glitch_drv_en_%0d", k), drv_en, cyc != 8'hff);
      check($sformatf("glitch_hall_sync_%0d", k), hall_sync, 3'b011);
    end
    check("glitch_state", state, 2'b10);

    hall_raw = 3'b111;
    step(5);
    check("inv_pre_run", state, 2'b10);
    step(1);
    check("inv_fault_state", state, 2'b11);
    check("inv_fault", fault, 1'b1);
    check("inv_cmd_ready", cmd_ready, 1'b0);
    check("inv_drv_en", drv_en, 1'b0);
    check("inv_period", period, 24'd0);
    cmd_valid = 1'b1; cmd_duty = 8'd9;
    step(3);
    cmd_valid = 1'b0;
    check("fault_holds", state, 2'b11);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("clr_idle", state, 2'b00);
    check("clr_fault", fault, 1'b0);
    check("clr_cmd_ready", cmd_ready, 1'b1);
    step(3);
    check("fault_cmd_dropped", state, 2'b00);

    hall_raw = 3'b001;
    step(12);
    cmd_valid = 1'b1; cmd_duty = 8'd10;
    step(1);
    cmd_valid = 1'b0;
    step(60);
    check("duty10_run", state, 2'b10);
    hall_raw = 3'b011;
    step(2006);
    check("stall_pre_run", state, 2'b10);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("stall_fault", state, 2'b11);
    check("stall_fault_flag", fault, 1'b1);
    step(1);
    check("stall_clr_ignored", state, 2'b11);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("stall_clr_idle", state, 2'b00);

    hall_raw = 3'b010;
    step(500);
    hall_raw = 3'b110;
    step(20);
`ifdef DRIBBLER_SPEED_EN
    check("period", period, 24'd500);
`else
    check("period", period, 24'd0);
`endif
    check("period_idle", state, 2'b00);

    cmd_valid = 1'b1; cmd_duty = 8'd4;
    step(1);
    cmd_valid = 1'b0;
    step(2);
    check("pre_async_ramp", state, 2'b01);
    rst_n = 1'b0;
    #2;
    check("async_state", state, 2'b00);
    check("async_drv_en", drv_en, 1'b0);
    check("async_fault", fault, 1'b0);
    check("async_hall_sync", hall_sync, 3'b000);
    check("async_cmd_ready", cmd_ready, 1'b1);
    check("async_period", period, 24'd0);
    rst_n = 1'b1;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end
endmodule
